// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: 4-register 8N1 UART slave with TX/RX FIFOs and a runtime baud divisor.
// Optional interrupt output is built when UART_FIFO_IRQ_EN is defined; otherwise irq is tied low.
module uart_fifo_ctrl #(
    parameter int unsigned UART_CLK   = 12000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rx,
    output logic       tx,
    output logic       irq
);
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam int unsigned DIV0_INT = UART_CLK / (BAUD_RATE * 8) - 1;
    localparam logic [7:0]  DIV0     = DIV0_INT[7:0];

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_BREAK = 3'd4;

    // Bus decode
    logic wr_data, rd_data, rd_stat, wr_ctrl, wr_div, clr_rx, clr_tx;
    assign wr_data = cs & we  & (addr == 2'd0);
    assign rd_data = cs & ~we & (addr == 2'd0);
    assign rd_stat = cs & ~we & (addr == 2'd1);
    assign wr_ctrl = cs & we  & (addr == 2'd2);
    assign wr_div  = cs & we  & (addr == 2'd3);
    assign clr_rx  = wr_ctrl & din[6];
    assign clr_tx  = wr_ctrl & din[7];

    // TX FIFO
    logic [7:0]  txf_mem [FIFO_DEPTH];
    logic [AW:0] txf_wp_q, txf_rp_q;
    logic        txf_empty, txf_full, txf_push, txf_pop;
    logic [7:0]  txf_head;
    assign txf_empty = (txf_wp_q == txf_rp_q);
    assign txf_full  = (txf_wp_q[AW] != txf_rp_q[AW]) &&
                       (txf_wp_q[AW-1:0] == txf_rp_q[AW-1:0]);
    assign txf_push  = wr_data & ~txf_full;
    assign txf_head  = txf_mem[txf_rp_q[AW-1:0]];

    // RX FIFO
    logic [7:0]  rxf_mem [FIFO_DEPTH];
    logic [AW:0] rxf_wp_q, rxf_rp_q;
    logic        rxf_empty, rxf_full, rxf_push, rxf_pop, rx_push_req;
    logic [7:0]  rx_sh_q, rx_sh_d;
    assign rxf_empty = (rxf_wp_q == rxf_rp_q);
    assign rxf_full  = (rxf_wp_q[AW] != rxf_rp_q[AW]) &&
                       (rxf_wp_q[AW-1:0] == rxf_rp_q[AW-1:0]);
    assign rxf_push  = rx_push_req & ~rxf_full;
    assign rxf_pop   = rd_data & ~rxf_empty;

    // FIFO storage writes (no reset needed, validity tracked by pointers)
    always_ff @(posedge clk) begin
        if (txf_push) txf_mem[txf_wp_q[AW-1:0]] <= din;
        if (rxf_push) rxf_mem[rxf_wp_q[AW-1:0]] <= rx_sh_d;
    end

    // FIFO pointers; a clear write empties the FIFO on the same edge
    always_ff @(posedge clk) begin
        if (rst || clr_tx) begin
            txf_wp_q <= '0;
            txf_rp_q <= '0;
        end else begin
            if (txf_push) txf_wp_q <= txf_wp_q + 1'b1;
            if (txf_pop)  txf_rp_q <= txf_rp_q + 1'b1;
        end
        if (rst || clr_rx) begin
            rxf_wp_q <= '0;
            rxf_rp_q <= '0;
        end else begin
            if (rxf_push) rxf_wp_q <= rxf_wp_q + 1'b1;
            if (rxf_pop)  rxf_rp_q <= rxf_rp_q + 1'b1;
        end
    end

    // Baud prescaler: counts 0..DIV, tick at 0; a DIV write restarts it
    logic [7:0] div_q, pre_q;
    logic       tick;
    assign tick = (pre_q == 8'd0);
    always_ff @(posedge clk) begin
        if (rst || wr_div)         pre_q <= 8'd0;
        else if (pre_q >= div_q)   pre_q <= 8'd0;
        else                       pre_q <= pre_q + 8'd1;
    end

    // TX next-state logic; tx is registered from the next state so it changes on the tick edge
    logic [1:0] tx_st_q, tx_st_d;
    logic [2:0] tx_tc_q, tx_tc_d, tx_bit_q, tx_bit_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic       tx_q, tx_d;
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_tc_d  = tx_tc_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        txf_pop  = 1'b0;
        case (tx_st_q)
            TX_IDLE: begin
                if (tick && !txf_empty) begin
                    txf_pop = 1'b1;
                    tx_sh_d = txf_head;
                    tx_tc_d = 3'd0;
                    tx_st_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    tx_tc_d = tx_tc_q + 3'd1;
                    if (tx_tc_q == 3'd7) begin
                        tx_bit_d = 3'd0;
                        tx_st_d  = TX_DATA;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    tx_tc_d = tx_tc_q + 3'd1;
                    if (tx_tc_q == 3'd7) begin
                        tx_sh_d = {1'b0, tx_sh_q[7:1]};
                        if (tx_bit_q == 3'd7) tx_st_d = TX_STOP;
                        else                  tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    tx_tc_d = tx_tc_q + 3'd1;
                    if (tx_tc_q == 3'd7) begin
                        // Chain straight into the next start bit so bursts have no gap
                        if (!txf_empty) begin
                            txf_pop = 1'b1;
                            tx_sh_d = txf_head;
                            tx_st_d = TX_START;
                        end else begin
                            tx_st_d = TX_IDLE;
                        end
                    end
                end
            end
            default: tx_st_d = TX_IDLE;
        endcase
        if (tx_st_d == TX_START)     tx_d = 1'b0;
        else if (tx_st_d == TX_DATA) tx_d = tx_sh_d[0];
        else                         tx_d = 1'b1;
    end

    // TX state registers; reset forces the line high immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st_q  <= TX_IDLE;
            tx_tc_q  <= 3'd0;
            tx_bit_q <= 3'd0;
            tx_sh_q  <= 8'd0;
            tx_q     <= 1'b1;
        end else begin
            tx_st_q  <= tx_st_d;
            tx_tc_q  <= tx_tc_d;
            tx_bit_q <= tx_bit_d;
            tx_sh_q  <= tx_sh_d;
            tx_q     <= tx_d;
        end
    end

    // RX next-state logic; samples land on the 4th tick of each bit after the start edge
    logic       rx_s1_q, rx_s2_q;
    logic [2:0] rx_st_q, rx_st_d, rx_tc_q, rx_tc_d, rx_tc_nx, rx_bit_q, rx_bit_d;
    logic       rx_smp, fe_set, ov_set;
    assign rx_tc_nx = rx_tc_q + 3'd1;
    assign rx_smp   = tick && (rx_tc_nx == 3'd4);
    assign ov_set   = rx_push_req & rxf_full;
    always_comb begin
        rx_st_d     = rx_st_q;
        rx_tc_d     = rx_tc_q;
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        rx_push_req = 1'b0;
        fe_set      = 1'b0;
        if (tick && (rx_st_q != RX_IDLE)) rx_tc_d = rx_tc_nx;
        case (rx_st_q)
            RX_IDLE: begin
                // IDLE is only entered with the line high, so a low level here is a falling edge
                if (!rx_s2_q) begin
                    rx_tc_d = 3'd0;
                    rx_st_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_smp) begin
                    if (rx_s2_q) begin
                        rx_st_d = RX_IDLE;
                    end else begin
                        rx_bit_d = 3'd0;
                        rx_st_d  = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_smp) begin
                    rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
                    else                  rx_bit_d = rx_bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_smp) begin
                    if (rx_s2_q) begin
                        rx_push_req = 1'b1;
                        rx_st_d     = RX_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        rx_st_d = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_s2_q) rx_st_d = RX_IDLE;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // RX synchroniser and state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q  <= 1'b1;
            rx_s2_q  <= 1'b1;
            rx_st_q  <= RX_IDLE;
            rx_tc_q  <= 3'd0;
            rx_bit_q <= 3'd0;
            rx_sh_q  <= 8'd0;
        end else begin
            rx_s1_q  <= rx;
            rx_s2_q  <= rx_s1_q;
            rx_st_q  <= rx_st_d;
            rx_tc_q  <= rx_tc_d;
            rx_bit_q <= rx_bit_d;
            rx_sh_q  <= rx_sh_d;
        end
    end

    // Status and sticky error flags; a status read clears them unless a new error lands that cycle
    logic       ov_q, fe_q, tx_idle, rx_avail, irq_stat;
    logic [1:0] ctrl_q;
    logic [7:0] status, rd_mux, dout_q;
    assign tx_idle  = txf_empty & (tx_st_q == TX_IDLE);
    assign rx_avail = ~rxf_empty;
    assign status   = {2'b00, irq_stat, fe_q, ov_q, tx_idle, rx_avail, txf_full};

    // Control, divisor and error-flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ov_q   <= 1'b0;
            fe_q   <= 1'b0;
            ctrl_q <= 2'b00;
            div_q  <= DIV0;
        end else begin
            ov_q <= (ov_q & ~rd_stat) | ov_set;
            fe_q <= (fe_q & ~rd_stat) | fe_set;
            if (wr_ctrl) ctrl_q <= din[1:0];
            if (wr_div)  div_q  <= din;
        end
    end

    // Read-data mux
    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            2'd0:    rd_mux = rxf_empty ? 8'h00 : rxf_mem[rxf_rp_q[AW-1:0]];
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = {6'b000000, ctrl_q};
            default: rd_mux = div_q;
        endcase
    end

    // Registered read data, held until the next read
    always_ff @(posedge clk) begin
        if (rst)            dout_q <= 8'h00;
        else if (cs && !we) dout_q <= rd_mux;
    end

`ifdef UART_FIFO_IRQ_EN
    logic irq_q;
    // Level interrupt, registered for one clock of latency
    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= (ctrl_q[0] & rx_avail) | (ctrl_q[1] & tx_idle) | ov_q | fe_q;
    end
    assign irq_stat = irq_q;
`else
    assign irq_stat = 1'b0;
`endif

    assign irq  = irq_stat;
    assign tx   = tx_q;
    assign dout = dout_q;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: bus tasks, a serial TX monitor with a scoreboard queue, an RX driver.
module tb_uart_fifo_ctrl;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       rx = 1'b1;
    logic       tx;
    logic       irq;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int bt = 104;
    int last_start = -1;
    bit mon_en = 1'b1;
    bit gap_chk = 1'b0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    uart_fifo_ctrl #(
        .UART_CLK  (12000000),
        .BAUD_RATE (115200),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cs  (cs),
        .we  (we),
        .addr(addr),
        .din (din),
        .dout(dout),
        .rx  (rx),
        .tx  (tx),
        .irq (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        d = dout;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (104) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (104) @(negedge clk);
        end
        rx = stop;
        repeat (104) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_tx_low(input string tag);
        int n = 0;
        while (tx !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(n < 5000), 1);
    endtask

    task automatic low_width(output int w);
        w = 0;
        while (tx === 1'b0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic wait_tx_drain(input string tag, input int lim);
        int n = 0;
        while (tx_exp.size() > 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, tx_exp.size(), 0);
    endtask

    task automatic rx_pop_chk(input string tag);
        logic [7:0] d;
        logic [7:0] e;
        bus_rd(2'd0, d);
        e = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'h00;
        check_val(tag, d, e);
    endtask

    // Decodes frames on tx mid-bit and compares them with the expected-byte queue
    initial begin : tx_mon
        logic [7:0] b;
        logic st, sp;
        int t0;
        forever begin
            @(negedge clk);
            if (!rst && mon_en && tx === 1'b0) begin
                t0 = cyc;
                if (gap_chk && last_start >= 0) check_val("tx_gap", t0 - last_start, 10 * bt);
                last_start = t0;
                repeat (bt / 2) @(negedge clk);
                st = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (bt) @(negedge clk);
                    b[i] = tx;
                end
                repeat (bt) @(negedge clk);
                sp = tx;
                check_val("tx_start_bit", st, 0);
                check_val("tx_stop_bit", sp, 1);
                check_val("tx_frame_expected", 32'(tx_exp.size() > 0), 1);
                if (tx_exp.size() > 0) check_val("tx_data", b, tx_exp.pop_front());
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] d;
        logic [7:0] v;
        logic [7:0] ctrl_v;
        int w;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_dout", dout, 8'h00);
        check_val("rst_tx", tx, 1);
        check_val("rst_irq", irq, 0);
        bus_rd(2'd1, d); check_val("rst_status", d, 8'h04);
        bus_rd(2'd2, d); check_val("rst_ctrl", d, 8'h00);
        bus_rd(2'd3, d); check_val("rst_div", d, 8'd12);

        // Single frame, 104 clocks per bit
        tx_exp.push_back(8'h55);
        bus_wr(2'd0, 8'h55);
        wait_tx_low("tx55_start_seen");
        low_width(w);
        check_val("tx_bit_104", w, 104);
        wait_tx_drain("tx55_drain", 3000);
        repeat (60) @(negedge clk);
        bus_rd(2'd1, d); check_val("tx_idle_after", d[2], 1);

        // Burst: one frame in flight, then fill the FIFO and overflow by one
        last_start = -1;
        gap_chk = 1'b1;
        tx_exp.push_back(8'h11);
        bus_wr(2'd0, 8'h11);
        repeat (30) @(negedge clk);
        bus_rd(2'd1, d);
        check_val("tx_not_full", d[0], 0);
        check_val("tx_busy", d[2], 0);
        for (int i = 0; i < DEPTH; i++) begin
            v = 8'(8'h20 + i);
            tx_exp.push_back(v);
            bus_wr(2'd0, v);
        end
        bus_rd(2'd1, d); check_val("tx_full_16", d[0], 1);
        bus_wr(2'd0, 8'hEE);
        bus_rd(2'd1, d); check_val("tx_full_17", d[0], 1);
        wait_tx_drain("tx_burst_drain", 20000);
        gap_chk = 1'b0;

        // Single RX byte
        rx_exp.push_back(8'hA3);
        send_rx(8'hA3, 1'b1);
        repeat (4) @(negedge clk);
        bus_rd(2'd1, d); check_val("rx_avail", d[1], 1);
        rx_pop_chk("rx_a3");
        bus_rd(2'd1, d); check_val("rx_avail_clr", d[1], 0);
        bus_rd(2'd0, d); check_val("rx_empty_read", d, 8'h00);

        // RX overrun
        for (int i = 0; i < DEPTH + 1; i++) begin
            v = 8'(8'h40 + i * 3);
            if (i < DEPTH) rx_exp.push_back(v);
            send_rx(v, 1'b1);
        end
        repeat (4) @(negedge clk);
        bus_rd(2'd1, d);
        check_val("ovr_set", d[3], 1);
        check_val("ovr_avail", d[1], 1);
        bus_rd(2'd1, d); check_val("ovr_clr", d[3], 0);
        for (int i = 0; i < DEPTH; i++) rx_pop_chk("rx_drain");
        bus_rd(2'd0, d); check_val("rx_drain_end", d, 8'h00);

        // Framing error, then a slower divisor
        send_rx(8'h5A, 1'b0);
        repeat (4) @(negedge clk);
        bus_rd(2'd1, d);
        check_val("frame_err", d[4], 1);
        check_val("fe_no_push", d[1], 0);
        bus_rd(2'd1, d); check_val("fe_clr", d[4], 0);
        bus_wr(2'd3, 8'd25);
        bus_rd(2'd3, d); check_val("div_rd", d, 8'd25);
        bt = 208;
        tx_exp.push_back(8'hFF);
        bus_wr(2'd0, 8'hFF);
        wait_tx_low("txff_start_seen");
        low_width(w);
        check_val("tx_bit_208", w, 208);
        wait_tx_drain("txff_drain", 5000);
        bus_wr(2'd3, 8'd12);
        bt = 104;

        // Interrupt behaviour
        rx_exp.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
`ifdef UART_FIFO_IRQ_EN
        ctrl_v = 8'h01;
        bus_wr(2'd2, ctrl_v);
        repeat (2) @(negedge clk);
        check_val("irq_set", irq, 1);
        bus_rd(2'd1, d); check_val("stat_irq", d[5], 1);
        rx_pop_chk("rx_irq_data");
        check_val("irq_hold", irq, 1);
        @(negedge clk);
        check_val("irq_clr", irq, 0);
`else
        ctrl_v = 8'h03;
        bus_wr(2'd2, ctrl_v);
        repeat (2) @(negedge clk);
        check_val("irq_tied", irq, 0);
        bus_rd(2'd1, d); check_val("stat_irq0", d[5], 0);
        rx_pop_chk("rx_3c");
`endif

        // clr_rx empties the RX FIFO; the pulse bit reads back 0
        send_rx(8'h77, 1'b1);
        repeat (4) @(negedge clk);
        bus_rd(2'd1, d); check_val("clr_pre_avail", d[1], 1);
        bus_wr(2'd2, ctrl_v | 8'h40);
        bus_rd(2'd1, d); check_val("clr_rx_avail", d[1], 0);
        bus_rd(2'd2, d); check_val("ctrl_rd", d, ctrl_v);
        bus_wr(2'd2, 8'h00);

        // Reset in the middle of a frame
        mon_en = 1'b0;
        bus_wr(2'd0, 8'h00);
        wait_tx_low("txrst_start_seen");
        repeat (30) @(negedge clk);
        check_val("tx_low_mid", tx, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("tx_rst", tx, 1);
        check_val("irq_rst", irq, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_rd(2'd1, d); check_val("post_rst_status", d, 8'h04);
        bus_rd(2'd3, d); check_val("post_rst_div", d, 8'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
